// File: rtl/gpr_mport.sv
// rtl/gpr_mport.sv - multi-port register file with scoreboard and sequential clear engine
module gpr_mport #(
    parameter int WIDTH  = 32,
    parameter int AW     = 5,
    parameter int NRD    = 3,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic                 we0,
    input  logic [AW-1:0]        waddr0,
    input  logic [WIDTH-1:0]     wdata0,
    input  logic                 we1,
    input  logic [AW-1:0]        waddr1,
    input  logic [WIDTH-1:0]     wdata1,
    input  logic                 iss_v,
    input  logic [AW-1:0]        iss_addr,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 clr_done
);

    localparam int DEPTH = 2**AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_t;

    clr_state_t       state;
    clr_state_t       state_nxt;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    idx_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;

    // Writes and issues are locked out while the clear engine owns the file.
    logic wr_en0;
    logic wr_en1;
    logic iss_en;

    assign clr_busy = (state == ST_CLEAR);
    assign clr_done = (state == ST_DONE);
    assign wr_en0   = we0   & ~clr_busy;
    assign wr_en1   = we1   & ~clr_busy;
    assign iss_en   = iss_v & ~clr_busy;

    // Clear FSM state and index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Clear FSM next state: one pass over every entry, then a one-cycle done pulse.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            ST_IDLE: begin
                if (clr_start) begin
                    state_nxt = ST_CLEAR;
                    idx_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (idx == AW'(DEPTH - 1)) begin
                    state_nxt = ST_DONE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Register storage; port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_busy) begin
            mem[idx] <= '0;
        end else begin
            if (wr_en0) begin
                mem[waddr0] <= wdata0;
            end
            if (wr_en1) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    // Scoreboard: writes retire a producer, an issue sets it last so a new producer wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (clr_busy) begin
            busy[idx] <= 1'b0;
        end else begin
            if (wr_en0) begin
                busy[waddr0] <= 1'b0;
            end
            if (wr_en1) begin
                busy[waddr1] <= 1'b0;
            end
            if (iss_en) begin
                busy[iss_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd;

        assign ra = raddr[k*AW +: AW];

        // Read mux with optional write forwarding; outputs forced low during reset.
        always_comb begin
            rd = mem[ra];
            if (BYPASS != 0) begin
                if (wr_en1 && (waddr1 == ra)) begin
                    rd = wdata1;
                end else if (wr_en0 && (waddr0 == ra)) begin
                    rd = wdata0;
                end
            end
            if (!rst_n) begin
                rd = '0;
            end
        end

        assign rdata[k*WIDTH +: WIDTH] = rd;
        assign rbusy[k]                = rst_n & busy[ra];
    end

endmodule

// File: tb/tb_gpr_mport.sv
// tb/tb_gpr_mport.sv - self-checking bench for gpr_mport, bypass and non-bypass builds
module tb_gpr_mport;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] raddr;
    logic [95:0] rdata_b;
    logic [95:0] rdata_n;
    logic [2:0]  rbusy_b;
    logic [2:0]  rbusy_n;
    logic        we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic        iss_v;
    logic [4:0]  iss_addr;
    logic        clr_start;
    logic        clr_busy_b;
    logic        clr_done_b;
    logic        clr_busy_n;
    logic        clr_done_n;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] mem_m  [32];
    bit          busy_m [32];

    always #5 clk = ~clk;

    gpr_mport #(.WIDTH(32), .AW(5), .NRD(3), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .iss_v(iss_v), .iss_addr(iss_addr),
        .clr_start(clr_start), .clr_busy(clr_busy_b), .clr_done(clr_done_b)
    );

    gpr_mport #(.WIDTH(32), .AW(5), .NRD(3), .BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .iss_v(iss_v), .iss_addr(iss_addr),
        .clr_start(clr_start), .clr_busy(clr_busy_n), .clr_done(clr_done_n)
    );

    // Expected combinational read: newest write this cycle wins when forwarding is on.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        v = mem_m[a];
        if (byp) begin
            if (we1 && waddr1 == a)      v = wdata1;
            else if (we0 && waddr0 == a) v = wdata0;
        end
        return v;
    endfunction

    task automatic model_zero();
        for (int i = 0; i < 32; i++) begin
            mem_m[i]  = '0;
            busy_m[i] = 1'b0;
        end
    endtask

    // One clock: apply the architectural effect of the current inputs, return at negedge.
    task automatic tick();
        @(posedge clk);
        if (we0) begin mem_m[waddr0] = wdata0; busy_m[waddr0] = 1'b0; end
        if (we1) begin mem_m[waddr1] = wdata1; busy_m[waddr1] = 1'b0; end
        if (iss_v) busy_m[iss_addr] = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we0 = 0; waddr0 = 0; wdata0 = 0;
        we1 = 0; waddr1 = 0; wdata1 = 0;
        iss_v = 0; iss_addr = 0; clr_start = 0;
    endtask

    task automatic fill_all();
        for (int a = 0; a < 32; a++) begin
            we0 = 1; waddr0 = 5'(a); wdata0 = $urandom | 32'h1;
            tick();
        end
        we0 = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        we1 = 1; waddr1 = 5'd4; wdata1 = 32'hFFFF_FFFF;
        iss_v = 1; iss_addr = 5'd4;
        raddr = {5'd4, 5'd4, 5'd4};
        #1;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (rdata_b[k*32 +: 32] !== 32'h0)
                $display("FAIL reset_rdata port%0d: got %h want 0", k, rdata_b[k*32 +: 32]);
            else n_pass++;
        end
        n_total++;
        if (rbusy_b !== 3'b000 || rbusy_n !== 3'b000)
            $display("FAIL reset_rbusy: got %b/%b want 000", rbusy_b, rbusy_n);
        else n_pass++;
        n_total++;
        if (clr_busy_b !== 1'b0 || clr_done_b !== 1'b0)
            $display("FAIL reset_fsm: busy=%b done=%b want 0/0", clr_busy_b, clr_done_b);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        model_zero();
        rst_n = 1;
    endtask

    task automatic test_write_port0();
        we0 = 1; waddr0 = 5'd3; wdata0 = 32'h1234_5678;
        tick();
        we0 = 0;
        raddr = {5'd0, 5'd0, 5'd3};
        #1;
        n_total++;
        if (rdata_b[31:0] !== 32'h1234_5678 || rdata_n[31:0] !== 32'h1234_5678)
            $display("FAIL write_port0: got %h/%h want 12345678", rdata_b[31:0], rdata_n[31:0]);
        else n_pass++;
    endtask

    task automatic test_collision();
        we0 = 1; waddr0 = 5'd7; wdata0 = 32'hAAAA_0000;
        we1 = 1; waddr1 = 5'd7; wdata1 = 32'h5555_FFFF;
        raddr = {5'd7, 5'd0, 5'd0};
        #1;
        n_total++;
        if (rdata_b[64 +: 32] !== 32'h5555_FFFF)
            $display("FAIL collision_bypass: got %h want 5555ffff", rdata_b[64 +: 32]);
        else n_pass++;
        tick();
        we0 = 0; we1 = 0;
        #1;
        n_total++;
        if (rdata_b[64 +: 32] !== 32'h5555_FFFF || rdata_n[64 +: 32] !== 32'h5555_FFFF)
            $display("FAIL collision_store: got %h/%h want 5555ffff",
                     rdata_b[64 +: 32], rdata_n[64 +: 32]);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        logic [3:0] got;
        logic [3:0] want;
        raddr = {5'd0, 5'd9, 5'd9};
        iss_v = 1; iss_addr = 5'd9;
        #1;
        n_total++;
        if (rbusy_b[0] !== 1'b0)
            $display("FAIL sb_issue_cycle: got %b want 0", rbusy_b[0]);
        else n_pass++;
        tick();
        iss_v = 0;
        #1; got[0] = rbusy_b[0];
        tick();
        we0 = 1; waddr0 = 5'd9; wdata0 = 32'h0000_0099;
        #1; got[1] = rbusy_b[0];
        tick();
        we0 = 0;
        #1; got[2] = rbusy_b[0];
        iss_v = 1; iss_addr = 5'd9;
        we1 = 1; waddr1 = 5'd9; wdata1 = 32'h0000_0999;
        tick();
        iss_v = 0; we1 = 0;
        #1; got[3] = rbusy_b[0];
        want = 4'b1011;
        n_total++;
        if (got !== want)
            $display("FAIL sb_sequence: got %b want %b", got, want);
        else n_pass++;
        n_total++;
        if (rbusy_n[1] !== 1'b1)
            $display("FAIL sb_port1_nb: got %b want 1", rbusy_n[1]);
        else n_pass++;
    endtask

    task automatic test_bypass0();
        logic [31:0] old_v;
        old_v = mem_m[5];
        we0 = 1; waddr0 = 5'd5; wdata0 = 32'hCAFE_0005;
        raddr = {5'd0, 5'd5, 5'd0};
        #1;
        n_total++;
        if (rdata_n[32 +: 32] !== old_v)
            $display("FAIL nobypass_same_cycle: got %h want %h", rdata_n[32 +: 32], old_v);
        else n_pass++;
        n_total++;
        if (rdata_b[32 +: 32] !== 32'hCAFE_0005)
            $display("FAIL bypass_same_cycle: got %h want cafe0005", rdata_b[32 +: 32]);
        else n_pass++;
        tick();
        we0 = 0;
        #1;
        n_total++;
        if (rdata_n[32 +: 32] !== 32'hCAFE_0005)
            $display("FAIL nobypass_after_edge: got %h want cafe0005", rdata_n[32 +: 32]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [4:0] a;
        for (int cyc = 0; cyc < 300; cyc++) begin
            we0 = 1'($urandom); waddr0 = 5'($urandom_range(0, 7)); wdata0 = $urandom;
            we1 = 1'($urandom); waddr1 = 5'($urandom_range(0, 7)); wdata1 = $urandom;
            iss_v = 1'($urandom); iss_addr = 5'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) raddr[k*5 +: 5] = 5'($urandom_range(0, 9));
            #1;
            for (int k = 0; k < 3; k++) begin
                a = raddr[k*5 +: 5];
                n_total++;
                if (rdata_b[k*32 +: 32] !== exp_rd(a, 1'b1))
                    $display("FAIL rand_rd_byp cyc%0d port%0d: got %h want %h",
                             cyc, k, rdata_b[k*32 +: 32], exp_rd(a, 1'b1));
                else n_pass++;
                n_total++;
                if (rdata_n[k*32 +: 32] !== exp_rd(a, 1'b0))
                    $display("FAIL rand_rd_nb cyc%0d port%0d: got %h want %h",
                             cyc, k, rdata_n[k*32 +: 32], exp_rd(a, 1'b0));
                else n_pass++;
                n_total++;
                if (rbusy_b[k] !== busy_m[a] || rbusy_n[k] !== busy_m[a])
                    $display("FAIL rand_busy cyc%0d port%0d: got %b/%b want %b",
                             cyc, k, rbusy_b[k], rbusy_n[k], busy_m[a]);
                else n_pass++;
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic readback_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(a), 5'(a), 5'(a)};
            #1;
            n_total++;
            if (rdata_b !== 96'h0 || rdata_n !== 96'h0)
                $display("FAIL %s_data addr%0d: got %h/%h want 0", tag, a, rdata_b, rdata_n);
            else n_pass++;
            n_total++;
            if (rbusy_b !== 3'b000)
                $display("FAIL %s_busy addr%0d: got %b want 000", tag, a, rbusy_b);
            else n_pass++;
        end
    endtask

    task automatic test_clear();
        bit exp_busy;
        bit exp_done;
        fill_all();
        clr_start = 1; iss_v = 1; iss_addr = 5'd20;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            exp_busy = (c <= 32);
            exp_done = (c == 33);
            n_total++;
            if (clr_busy_b !== exp_busy || clr_done_b !== exp_done)
                $display("FAIL clear_cycle%0d: busy=%b done=%b want %b/%b",
                         c, clr_busy_b, clr_done_b, exp_busy, exp_done);
            else n_pass++;
            if (c == 1) begin clr_start = 0; iss_v = 0; end
            if (c == 16) begin
                we0 = 1; waddr0 = 5'd31; wdata0 = 32'hDEAD_BEEF;
                raddr = {5'd0, 5'd0, 5'd31};
                #1;
                n_total++;
                if (rdata_b[31:0] !== mem_m[31])
                    $display("FAIL clear_no_bypass: got %h want %h", rdata_b[31:0], mem_m[31]);
                else n_pass++;
            end
            if (c == 17) we0 = 0;
            if (c == 33) clr_start = 1;
            if (c == 34) clr_start = 0;
        end
        model_zero();
        readback_zero("clear");
    endtask

    task automatic test_reset_mid_clear();
        bit saw_done;
        bit saw_busy;
        fill_all();
        raddr = {5'd31, 5'd31, 5'd31};
        clr_start = 1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) clr_start = 0;
        end
        #1;
        rst_n = 0;
        #1;
        n_total++;
        if (clr_busy_b !== 1'b0 || rdata_b[31:0] !== 32'h0 || rbusy_b !== 3'b000)
            $display("FAIL midclear_async: busy=%b rdata=%h rbusy=%b want 0/0/0",
                     clr_busy_b, rdata_b[31:0], rbusy_b);
        else n_pass++;
        @(negedge clk);
        rst_n = 1;
        model_zero();
        saw_done = 0; saw_busy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (clr_done_b) saw_done = 1;
            if (clr_busy_b) saw_busy = 1;
        end
        n_total++;
        if (saw_done !== 1'b0 || saw_busy !== 1'b0)
            $display("FAIL midclear_after_release: done_seen=%b busy_seen=%b want 0/0",
                     saw_done, saw_busy);
        else n_pass++;
        readback_zero("midclear");
    endtask

    initial begin
        idle_inputs();
        raddr = '0;
        model_zero();
        test_reset();
        test_write_port0();
        test_collision();
        test_scoreboard();
        test_bypass0();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gpr_mport.md
GPR_MPORT -- requirements
Module: gpr_mport

Interface
REQ-001 Parameter WIDTH, default 32: register data width in bits.
REQ-002 Parameter AW, default 5: address width; DEPTH = 2**AW entries.
REQ-003 Parameter NRD, default 3: number of read ports, legal range 1..6.
REQ-004 Parameter BYPASS, default 1: 1 enables same-cycle write-to-read forwarding; 0 disables it.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 raddr  input  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
REQ-008 rdata  output  NRD*WIDTH  read data; port k occupies bits [k*WIDTH +: WIDTH].
REQ-009 rbusy  output  NRD  scoreboard pending bit for each read address.
REQ-010 we0, waddr0, wdata0  input  1/AW/WIDTH  write port 0 (ALU result).
REQ-011 we1, waddr1, wdata1  input  1/AW/WIDTH  write port 1 (load / update result).
REQ-012 iss_v, iss_addr  input  1/AW  issue: mark a destination register as pending.
REQ-013 clr_start  input  1  single-cycle pulse that starts a sequential clear of the whole file.
REQ-014 clr_busy  output  1  high while the clear engine is running.
REQ-015 clr_done  output  1  single-cycle pulse on clear completion.

Function
REQ-016 Reads are combinational: rdata[k] = entry[raddr[k]], zero-cycle latency.
REQ-017 A write takes effect at the clock edge where we0 or we1 is sampled high.
REQ-018 If we0 and we1 target the same address in one cycle, wdata1 is stored and wdata0 is discarded.
REQ-019 If BYPASS=1 and raddr[k] matches an active write address, rdata[k] returns that write data in the same cycle; port 1 takes priority over port 0.
REQ-020 If BYPASS=0, rdata[k] returns the stored value until the next clock edge.
REQ-021 Scoreboard: one busy bit per entry; iss_v sets busy[iss_addr]; a write on either port clears busy[waddr].
REQ-022 If iss_v and a write hit the same address in the same cycle, busy is set (the new producer wins).
REQ-023 rbusy[k] = busy[raddr[k]], combinational, with no bypass of the same-cycle set or clear.
REQ-024 Clear FSM has three states: IDLE, CLEAR, DONE.
REQ-025 IDLE -> CLEAR when clr_start=1; the index counter loads 0.
REQ-026 CLEAR: each cycle writes 0 to entry[idx], clears busy[idx], and increments idx; after idx = DEPTH-1 -> DONE, so CLEAR lasts exactly DEPTH cycles.
REQ-027 DONE: clr_done=1 for one cycle, then -> IDLE.
REQ-028 clr_busy=1 in the CLEAR state only.
REQ-029 While clr_busy=1, we0, we1 and iss_v are ignored, and bypass is disabled.
REQ-030 clr_start is ignored outside IDLE, including during DONE.
REQ-031 The idx counter is AW bits wide and must not wrap into a second pass.

Reset
REQ-032 Assertion of rst_n=0, at any time and independent of clk, sets all entries to 0, all busy bits to 0, the FSM to IDLE, idx to 0, and clr_busy and clr_done to 0.
REQ-033 Reset during CLEAR aborts the sequence; after release the FSM is in IDLE and clr_done is not pulsed.
REQ-034 While in reset, rdata = 0 and rbusy = 0 for every port.

Verification
REQ-035 Write port 0: we0=1, waddr0=3, wdata0=0x12345678 -> after the edge, raddr[0]=3 reads 0x12345678.
REQ-036 Port collision: we0 and we1 both to address 7 with values 0xAAAA0000 and 0x5555FFFF -> entry 7 holds 0x5555FFFF; with BYPASS=1, a same-cycle read of 7 returns 0x5555FFFF.
REQ-037 Scoreboard: iss_v to r9, then write r9 two cycles later -> rbusy for r9 is 1 for two cycles, then 0; a same-cycle iss_v and write to r9 leaves rbusy=1.
REQ-038 Clear: fill all 32 entries, pulse clr_start -> clr_busy high for exactly 32 cycles, clr_done pulses in cycle 33, and all reads return 0; a we0 issued mid-clear has no effect.
REQ-039 Reset mid-clear: assert rst_n=0 at idx=10 -> FSM in IDLE, all entries 0, and no clr_done pulse after release.
REQ-040 BYPASS=0 build: a same-cycle read of a written address returns the old value; the new value is visible after the edge.
